la_pattern_generator: RTL
=========================

// Module: la_pattern_generator
// PURPOSE
// - Transmit-side counterpart of the logic analyzer capture engine: replays a host-loaded buffer of 32-bit words
//   onto tx_data, one word per clk, with a trigger marker (tx_trigger) on a programmable word.
// - Host side loads the buffer through a simple write port, latches length/trigger position and pulses start.
// - Single clock domain; any CDC to a bus clock is done outside this block.
// PARAMETERS
// - BUF_SIZE   'h8000   playback buffer depth in 32-bit words; power of two, >= 4
// - ADDR_BITS  $clog2(BUF_SIZE)   derived localparam, not overridable
// PORTS
// - clk         in   1            clock; everything is synchronous to it
// - rst         in   1            synchronous, active-high reset
// - wr_en       in   1            buffer write strobe
// - wr_addr     in   ADDR_BITS    buffer write address
// - wr_data     in   32           buffer write data
// - start       in   1            single-cycle pulse: begin playback
// - stop        in   1            single-cycle pulse: abort playback
// - play_len    in   ADDR_BITS+1  words to play, 1..BUF_SIZE; latched on accepted start
// - trig_pos    in   ADDR_BITS    word index carrying tx_trigger; latched on accepted start
// - trig_wait   in   1            1 = hold after start until ext_trig; latched on accepted start
// - ext_trig    in   1            external arm trigger, level-sampled in WAIT_TRIG only
// - tx_data     out  32           playback word; 0 whenever tx_valid=0
// - tx_valid    out  1            tx_data holds a buffer word
// - tx_trigger  out  1            high with tx_valid on word index trig_pos
// - busy        out  1            high in any state other than IDLE
// - done        out  1            one-cycle pulse after final word of a completed playback
// - wr_err      out  1            one-cycle pulse: wr_en while busy (write discarded)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, read pipeline flushed; buffer contents are NOT cleared.
// - Buffer: simple dual-port inferred block RAM, read latency 1 plus one output register (2-cycle pipe).
// - Writes accepted only in IDLE: written the edge after wr_en. wr_en while busy -> discarded, wr_err next cycle.
// - States: IDLE -> (start, play_len!=0) -> WAIT_TRIG if trig_wait else PLAY; WAIT_TRIG -> (ext_trig) -> PLAY;
//   PLAY issues read addresses 0..play_len-1, one per cycle, then -> DRAIN; DRAIN waits 2 cycles for pipe -> IDLE.
// - Latency: start (or ext_trig in WAIT_TRIG) sampled at edge 0 -> word 0 on tx_data with tx_valid after edge 3.
//   Words then contiguous, no gaps, play_len cycles of tx_valid.
// - done and busy=0 appear together in the cycle immediately after the last tx_valid cycle.
// - play_len compared at ADDR_BITS+1 width; play_len=BUF_SIZE plays whole buffer; play_len > BUF_SIZE is
//   clamped to BUF_SIZE; start with play_len=0 ignored (no busy, no done).
// - trig_pos >= latched play_len: tx_trigger never asserts.
// - start while busy: ignored. start and stop same cycle: stop wins (remain/return IDLE, no done).
// - stop in any busy state: after that edge busy=0, tx_valid=0, tx_trigger=0, tx_data=0; in-flight reads dropped;
//   no done pulse.
// - rst mid-playback: same as stop but also clears wr_err/done; new start accepted in the cycle after rst drops.
// CONFIGURATION
// - PATGEN_LOOP_EN defined: adds input loop_en (1 bit, latched on accepted start). With loop_en=1, after word
//   play_len-1 the next cycle carries word 0 again (no gap, no DRAIN); tx_trigger asserts once per pass;
//   done never pulses; only stop/rst end playback. loop_en=0 behaves as single-shot.
// - PATGEN_LOOP_EN undefined: loop_en port absent; single-shot playback only.
// TESTING
// - Load words i -> 32'hA500_0000+i for i=0..7; play_len=8, trig_pos=3, start -> tx_valid after edge 3 for 8
//   cycles, data A5000000..A5000007, tx_trigger only on A5000003, done 1 cycle after last word.
// - trig_wait=1, start, ext_trig held 0 for 20 cycles then pulsed -> no tx_valid for 20 cycles, word 0 three
//   cycles after ext_trig, busy high throughout.
// - stop on 3rd tx_valid cycle of play_len=8 -> next cycle tx_valid=0, busy=0, tx_data=0, no done; a new start
//   then replays from word 0.
// - wr_en to addr 2 with data FFFF_FFFF while busy -> wr_err pulse; replay after done still shows A5000002.
// - play_len=0 start -> busy stays 0, no done; play_len=BUF_SIZE, trig_pos=BUF_SIZE-1 -> BUF_SIZE valid words,
//   tx_trigger on last word only.
// - PATGEN_LOOP_EN, loop_en=1, play_len=4, trig_pos=0 -> A5000000..03 repeating gap-free, tx_trigger every 4th
//   cycle, no done; stop ends it with no done pulse.

Source files
------------

// File: rtl/la_pattern_generator_if.sv
// Host/playback bus of the logic-analyzer pattern generator.
// Groups the buffer write port, playback control, and the transmit stream.
// When PATGEN_LOOP_EN is defined, the bus also carries the loop_en control bit.
interface la_pattern_generator_if #(
  parameter int BUF_SIZE = 'h8000
);
  localparam int ADDR_BITS = $clog2(BUF_SIZE);

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic                 start;
  logic                 stop;
  logic [ADDR_BITS:0]   play_len;
  logic [ADDR_BITS-1:0] trig_pos;
  logic                 trig_wait;
  logic                 ext_trig;
`ifdef PATGEN_LOOP_EN
  logic                 loop_en;
`endif
  logic [31:0]          tx_data;
  logic                 tx_valid;
  logic                 tx_trigger;
  logic                 busy;
  logic                 done;
  logic                 wr_err;

  // Host side: loads the buffer, controls playback, consumes the stream.
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, play_len, trig_pos, trig_wait, ext_trig,
`ifdef PATGEN_LOOP_EN
    output loop_en,
`endif
    input  tx_data, tx_valid, tx_trigger, busy, done, wr_err
  );

  // Generator side.
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, play_len, trig_pos, trig_wait, ext_trig,
`ifdef PATGEN_LOOP_EN
    input  loop_en,
`endif
    output tx_data, tx_valid, tx_trigger, busy, done, wr_err
  );
endinterface

// File: rtl/la_pattern_generator.sv
// Logic-analyzer pattern generator.
// Replays a host-loaded buffer of 32-bit words onto tx_data, one word per clock.
// tx_trigger marks one programmable word index.
// The read path is three registers deep:
//   issue register -> block-RAM read register -> output register.
// As a result, word 0 appears three edges after PLAY is entered.
// Optional feature: define PATGEN_LOOP_EN for gap-free looped playback.
module la_pattern_generator #(
  parameter int BUF_SIZE = 'h8000
) (
  input  logic                  clk,
  input  logic                  rst,
  la_pattern_generator_if.slave bus
);
  localparam int ADDR_BITS = $clog2(BUF_SIZE);
  localparam logic [ADDR_BITS:0]   FULL_LEN = (ADDR_BITS+1)'(BUF_SIZE);
  localparam logic [ADDR_BITS:0]   LEN_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, PLAY, DRAIN} state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] cnt_q;        // next word index to issue
  logic [ADDR_BITS-1:0] last_q;       // index of the final word (length - 1)
  logic [ADDR_BITS-1:0] trig_pos_q;
  logic                 loop_q;
  logic                 rd_vld_q, rd_trig_q;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic                 mem_vld_q, mem_trig_q;
  logic [31:0]          mem_rd_q;
  logic                 tx_valid_q, tx_trigger_q;
  logic [31:0]          tx_data_q;
  logic                 busy_q, done_q, wr_err_q;

  logic [31:0]          mem [BUF_SIZE];

  logic [ADDR_BITS:0]   len_d;
  logic [ADDR_BITS-1:0] last_d;
  logic                 loop_d;
  logic                 start_ok;

  // Lengths above the buffer depth replay the whole buffer.
  // A zero length never starts playback.
  assign len_d    = (bus.play_len > FULL_LEN) ? FULL_LEN : bus.play_len;
  assign last_d   = ADDR_BITS'(len_d - LEN_ONE);
  assign start_ok = bus.start && !bus.stop && (bus.play_len != '0);

`ifdef PATGEN_LOOP_EN
  assign loop_d = bus.loop_en;
`else
  assign loop_d = 1'b0;
`endif

  // Playback buffer: host writes only while idle; one registered read per cycle.
  // NOTE: the storage array has no reset, so it can map onto block RAM; the valid flags in the
  // pipeline, not the data, decide what reaches tx_data.
  always_ff @(posedge clk) begin
    if (bus.wr_en && state_q == IDLE) mem[bus.wr_addr] <= bus.wr_data;
    mem_rd_q <= mem[rd_addr_q];
  end

  // Control FSM plus read pipeline, all outputs registered.
  // NOTE: every state element here uses non-blocking assignment, so each register samples the
  // values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      trig_pos_q   <= '0;
      loop_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_trig_q    <= 1'b0;
      rd_addr_q    <= '0;
      mem_vld_q    <= 1'b0;
      mem_trig_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_trigger_q <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      // Default: the pipeline shifts and pulses drop.
      rd_vld_q     <= 1'b0;
      rd_trig_q    <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= bus.wr_en && (state_q != IDLE);
      mem_vld_q    <= rd_vld_q;
      mem_trig_q   <= rd_trig_q;
      tx_valid_q   <= mem_vld_q;
      tx_trigger_q <= mem_vld_q && mem_trig_q;
      tx_data_q    <= mem_vld_q ? mem_rd_q : '0;

      if (bus.stop && state_q != IDLE) begin
        // Abort: drop everything in flight and go quiet immediately, with no done pulse.
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        mem_vld_q    <= 1'b0;
        mem_trig_q   <= 1'b0;
        tx_valid_q   <= 1'b0;
        tx_trigger_q <= 1'b0;
        tx_data_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_ok) begin
              last_q     <= last_d;
              trig_pos_q <= bus.trig_pos;
              loop_q     <= loop_d;
              cnt_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= bus.trig_wait ? WAIT_TRIG : PLAY;
            end
          end
          WAIT_TRIG: begin
            if (bus.ext_trig) state_q <= PLAY;
          end
          PLAY: begin
            rd_vld_q  <= 1'b1;
            rd_addr_q <= cnt_q;
            rd_trig_q <= (cnt_q == trig_pos_q);
            if (cnt_q == last_q) begin
              cnt_q <= '0;
              if (!loop_q) state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + ADDR_ONE;
            end
          end
          DRAIN: begin
            // The last word is in the output register once both earlier stages are empty.
            if (!rd_vld_q && !mem_vld_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_trigger = tx_trigger_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wr_err     = wr_err_q;

endmodule
